wb_arb2: RTL

Two-master Wishbone arbiter placed directly upstream of the on-chip Wishbone RAM slave. It multiplexes the OpenRISC instruction bus (master 0) and data bus (master 1) onto the single RAM port. Grant is round-robin, locked for the whole `cyc` of the owning master. A watchdog terminates any access the slave fails to acknowledge, returning `err`.

---
 rtl/wb_arb2.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter in front of the on-chip RAM slave: round-robin grant locked
// for the owner's whole cyc, with a watchdog that turns a missing ack into an err pulse.
module wb_arb2 #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [3:0]      m0_sel_i,
  input  logic [31:0]     m0_adr_i,
  input  logic [31:0]     m0_dat_i,
  output logic [31:0]     m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [3:0]      m1_sel_i,
  input  logic [31:0]     m1_adr_i,
  input  logic [31:0]     m1_dat_i,
  output logic [31:0]     m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [3:0]      s_sel_o,
  output logic [31:0]     s_adr_o,
  output logic [31:0]     s_dat_o,
  input  logic [31:0]     s_dat_i,
  input  logic            s_ack_i,

  output logic [1:0]      dbg_state_o,
  output logic [TO_W-1:0] dbg_cnt_o
);

  // Handshake: a transfer is offered while cyc & stb are high and completes in the cycle
  // the slave raises ack (or the watchdog raises err); the master holds its request until then.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic            r_last;
  logic [TO_W-1:0] r_cnt;
  logic            r_err_pending;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_expire;
  logic [TO_W-1:0] w_cnt_nxt;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    if (w_gnt0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & ~r_err_pending;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (w_gnt1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & ~r_err_pending;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_ack_o = s_ack_i & w_gnt0;
  assign m1_ack_o = s_ack_i & w_gnt1;
  assign m0_err_o = r_err_pending & w_gnt0;
  assign m1_err_o = r_err_pending & w_gnt1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // An ack in the expiry cycle wins, so expiry requires the slave to still be silent.
  assign w_expire = s_stb_o & ~s_ack_i & (r_cnt == CNT_MAX);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (s_ack_i || r_err_pending || w_expire) begin
      w_cnt_nxt = '0;
    end else if (s_stb_o && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state       <= IDLE;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_err_pending <= 1'b0;
    end else begin
      r_err_pending <= w_expire;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_last ? GNT0 : GNT1;
            r_last  <= ~r_last;
          end else if (m0_cyc_i) begin
            r_state <= GNT0;
            r_last  <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state <= GNT1;
            r_last  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            r_cnt <= '0;
            if (m1_cyc_i) begin
              r_state <= GNT1;
              r_last  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            r_cnt <= '0;
            if (m0_cyc_i) begin
              r_state <= GNT0;
              r_last  <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign dbg_state_o = r_state;
  assign dbg_cnt_o   = r_cnt;

endmodule
